mem_port_arbiter: RTL

//  Shares one single-port unified memory between the IF-stage fetch port and the
//  MEM-stage load/store port of the 5-stage pipeline. Serialises the two accesses

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory between fetch and load/store.
// Data access goes first, then fetch; the pipeline stalls until the step is done.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_valid_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_valid_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        D_BUSY,
        I_BUSY,
        DONE
    } state_t;

    // Last non-ack cycle before the counter would reach TIMEOUT
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        d_rd;
    logic        d_seen;
    logic        d_req;
    logic        to_hit;

    assign d_req  = d_read_i | d_write_i;
    assign to_hit = !mem_ack_i && (wait_cnt == TO_LIM);

    assign stall_o = (state == D_BUSY) || (state == I_BUSY) ||
                     ((state == IDLE) && (d_req || if_req_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            d_rd        <= 1'b0;
            d_seen      <= 1'b0;
            if_data_o   <= '0;
            if_valid_o  <= 1'b0;
            d_rdata_o   <= '0;
            d_valid_o   <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            if_valid_o <= 1'b0;
            d_valid_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_req) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= d_write_i;
                        mem_addr_o  <= d_addr_i;
                        mem_wdata_o <= d_wdata_i;
                        d_rd        <= d_read_i & ~d_write_i;
                        wait_cnt    <= '0;
                        state       <= D_BUSY;
                    end else if (if_req_i) begin
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= if_addr_i;
                        wait_cnt   <= '0;
                        state      <= I_BUSY;
                    end
                end
                D_BUSY: begin
                    if (mem_ack_i) begin
                        if (d_rd)
                            d_rdata_o <= mem_rdata_i;
                        mem_we_o <= 1'b0;
                        if (if_req_i) begin
                            mem_addr_o <= if_addr_i;
                            wait_cnt   <= '0;
                            d_seen     <= 1'b1;
                            state      <= I_BUSY;
                        end else begin
                            mem_req_o <= 1'b0;
                            d_valid_o <= 1'b1;
                            state     <= DONE;
                        end
                    end else if (to_hit) begin
                        // Abort: data kept, pending fetch skipped
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        err_o     <= 1'b1;
                        d_valid_o <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                I_BUSY: begin
                    if (mem_ack_i || to_hit) begin
                        if (mem_ack_i)
                            if_data_o <= mem_rdata_i;
                        else
                            err_o <= 1'b1;
                        mem_req_o  <= 1'b0;
                        if_valid_o <= 1'b1;
                        d_valid_o  <= d_seen;
                        state      <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DONE: begin
                    d_seen <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
